// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with valid/ready handshake
// and a 2-entry skid buffer so o_ready never depends combinationally on i_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_inst,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [2:0]       o_fmt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);
    localparam int W = XLEN + 4 + TAG_W;

    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [W-1:0]    new_e, out_q, out_d, skid_q, skid_d;
    logic            out_v_q, out_v_d, skid_v_q, skid_v_d, accept, drain;

    always_comb begin
        imm = '0;
        fmt = 3'd0;
        ill = 1'b0;
        case (i_inst[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                fmt = 3'd1;
                imm = XLEN'($signed(i_inst[31:20]));
            end
            7'b0100011: begin
                fmt = 3'd2;
                imm = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
            end
            7'b1100011: begin
                fmt = 3'd3;
                imm = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4;
                imm = XLEN'($signed({i_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                fmt = 3'd5;
                imm = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
            end
            7'b1110011: begin
                fmt = i_inst[14] ? 3'd6 : 3'd1;
                imm = i_inst[14] ? XLEN'(i_inst[19:15]) : XLEN'($signed(i_inst[31:20]));
            end
            7'b0110011: fmt = 3'd0;
            7'b0011011: begin
                ill = (XLEN != 64);
                fmt = ill ? 3'd0 : 3'd1;
                imm = ill ? '0 : XLEN'($signed(i_inst[31:20]));
            end
            7'b0111011: ill = (XLEN != 64);
            default:    ill = 1'b1;
        endcase
    end

    assign new_e  = {imm, fmt, ill, i_tag};
    assign accept = i_valid && !skid_v_q;
    assign drain  = out_v_q && i_ready;

    // skid only fills when out is stalled, so a full skid always refills out first
    always_comb begin
        out_d    = out_q;
        skid_d   = skid_q;
        out_v_d  = out_v_q;
        skid_v_d = skid_v_q;
        if (skid_v_q) begin
            if (drain) begin
                out_d    = skid_q;
                skid_v_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_v_q || drain) begin
                out_d   = new_e;
                out_v_d = 1'b1;
            end else begin
                skid_d   = new_e;
                skid_v_d = 1'b1;
            end
        end else if (drain) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q    <= '0;
            skid_q   <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            skid_q   <= skid_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign {o_imm, o_fmt, o_illegal, o_tag} = out_q;
    assign o_valid = out_v_q;
    assign o_ready = !skid_v_q;
endmodule
